frame_scanout_arbiter: RTL and testbench
========================================

# frame_scanout_arbiter

Shares the single-port Game Boy frame buffer (160×144, 2-bit shades) between the PPU pixel writer and VGA scanout. It sits beside the 640×480 VGA timing generator and consumes its DrawX/DrawY. Source lines are prefetched into ping-pong line buffers and scaled 3× into a centred 480×432 window. PPU writes get priority, and a deadline monitor flags scanout underrun.

## Interface
Parameters:
- FB_AW, 15: frame-buffer address width (23040 entries).
- X_OFF, 80: first DrawX of the window.
- Y_OFF, 24: first DrawY of the window.

Ports:
- Clk  in  1  pixel clock, shared with the VGA timing generator.
- Reset  in  1  asynchronous, active-high.
- DrawX  in  10  current column, 0–799.
- DrawY  in  10  current line, 0–524.
- wr_req  in  1  PPU write request; held until wr_ack.
- wr_addr  in  FB_AW  PPU write address (row*160+col).
- wr_data  in  2  PPU shade.
- wr_ack  out  1  one-cycle grant pulse.
- mem_addr  out  FB_AW  frame-buffer address.
- mem_we  out  1  frame-buffer write enable.
- mem_wdata  out  2  frame-buffer write data.
- mem_rdata  in  2  read data, valid one cycle after address with mem_we=0.
- pixel_shade  out  2  scaled output shade.
- pixel_valid  out  1  high while the pixel is inside the 480×432 window.
- underrun  out  1  sticky: a fetch missed its deadline.

## Operation
- Window: DrawX 80–559, DrawY 24–455. Each source pixel covers 3×3 screen pixels. Scaling uses counters, with no divider:
  - col_phase and src_col reset at DrawX==X_OFF−1.
  - row_phase and src_row advance at DrawX==799.
- Fetch events:
  - At DrawX==0 and DrawY==0: fetch source row 0 into buffer 0.
  - At DrawX==0 on the first screen line of each source row r<143: fetch row r+1 into the buffer not being read.
  - The read-buffer select toggles after the third screen line of each group.
- Fetch FSM states:
  - IDLE → FETCH on a fetch event.
  - FETCH issues reads for cols 0..159 at base row*160. The base is an accumulated +160 register, with no multiplier.
  - FETCH → DRAIN after col 159 issues.
  - DRAIN → IDLE when the last rdata is written.
  - Returned data is written to the line buffer at the column captured one cycle earlier.
- Arbitration, evaluated each cycle:
  - wr_req wins: mem_we=1, mem_addr=wr_addr, wr_ack=1.
  - Otherwise, when FETCH is active, issue a read.
  - A stalled fetch keeps its column counter.
- Deadline: a fetch event arriving while the FSM is not IDLE sets underrun. The in-flight fetch is aborted, in-flight rdata is discarded, and the new fetch starts.
- Simultaneous wr_req and a fetch event: the write is granted, and FETCH starts the same cycle but issues nothing until the next free cycle.

## Timing
- Reset values: wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, pixel_shade=0, pixel_valid=0, underrun=0, FSM=IDLE, read select=0, all counters 0.
- pixel_shade and pixel_valid are registered, one cycle after the DrawX/DrawY they correspond to. Downstream delays syncs by one.
- wr_ack is combinational with the grant, in the same cycle that mem_we is high. A new request may be presented the cycle after ack.
- Minimum fetch: 161 cycles (160 issues plus 1 drain). Budget: 2400 cycles (3 lines).
- Outside the window: pixel_valid=0 and pixel_shade=0.
- Reset mid-fetch: immediate return to IDLE. Line-buffer contents are undefined until the next frame start.

## Configuration
- FBARB_STARVE_GUARD_EN:
  - Defined: after 8 consecutive write grants while FETCH is pending, the next cycle goes to the fetch and wr_ack is withheld.
  - Undefined: strict write priority; underrun is possible under sustained writes.

## Structure
- Package fb_pkg holds:
  - constants GB_W=160, GB_H=144, SCALE=3, FB_DEPTH=23040;
  - typedef shade_t (logic [1:0]);
  - enum fetch_state_t {IDLE, FETCH, DRAIN}.
- Sub-module scan_line_buffer: 2×160×2-bit simple dual-port RAM.
  - Write port: fetch side.
  - Read port: scanout side, registered read.

## Test plan
- Frame start, no writes: fetch of row 0 spans DrawX 0..160 of line 0. At DrawX=80, DrawY=24, pixel_shade equals fb[0] one cycle later; columns 80–82 repeat the same shade.
- Frame buffer holds fb[row*160+col]=col[1:0]. At DrawY=27 (row 1), DrawX=83 → shade of fb[161]=1. At DrawX=559 → shade of fb[319]=3.
- Single write wr_addr=5, wr_data=2 during FETCH: wr_ack and mem_we high in the same cycle. The fetch column holds for one cycle. The fetch completes at 162 cycles.
- wr_req held high continuously, macro undefined: underrun=1 at the next fetch event (DrawY=27, DrawX=0).
- Same as the previous scenario with the macro defined: a fetch read occurs every 9th cycle, the fetch completes within 2400 cycles, and underrun=0.
- Reset asserted at DrawX=50 mid-fetch: all outputs 0 next edge, FSM=IDLE; after release, underrun stays 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the Game Boy frame-buffer scanout arbiter.
package fb_pkg;

    localparam int unsigned GB_W     = 160;
    localparam int unsigned GB_H     = 144;
    localparam int unsigned SCALE    = 3;
    localparam int unsigned FB_DEPTH = 23040;

    typedef logic [1:0] shade_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/scan_line_buffer.sv
// Ping-pong pair of 160-entry shade line buffers: fetch-side write port and
// scanout-side registered read port that outputs 0 when not enabled.
module scan_line_buffer
    import fb_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_we,
    input  logic       i_wsel,
    input  logic [7:0] i_wcol,
    input  logic [1:0] i_wdata,
    input  logic       i_re,
    input  logic       i_rsel,
    input  logic [7:0] i_rcol,
    output logic [1:0] o_rdata
);

    shade_t r_mem [0:1][0:GB_W-1];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_wsel][i_wcol] <= i_wdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_rsel][i_rcol];
        end else begin
            o_rdata <= '0;
        end
    end

endmodule

// File: rtl/frame_scanout_arbiter.sv
// Frame-buffer arbiter: PPU writes vs. line prefetch for 3x scaled VGA scanout.
// Optional FBARB_STARVE_GUARD_EN: force a fetch read after 8 back-to-back write grants.
module frame_scanout_arbiter
    import fb_pkg::*;
#(
    parameter int FB_AW = 15,
    parameter int X_OFF = 80,
    parameter int Y_OFF = 24
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             wr_req,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [1:0]       wr_data,
    output logic             wr_ack,
    output logic [FB_AW-1:0] mem_addr,
    output logic             mem_we,
    output logic [1:0]       mem_wdata,
    input  logic [1:0]       mem_rdata,
    output logic [1:0]       pixel_shade,
    output logic             pixel_valid,
    output logic             underrun
);

    localparam logic [9:0]       X_FIRST    = 10'(X_OFF);
    localparam logic [9:0]       X_PRE      = 10'(X_OFF - 1);
    localparam logic [9:0]       X_END      = 10'(X_OFF + GB_W * SCALE);
    localparam logic [9:0]       Y_FIRST    = 10'(Y_OFF);
    localparam logic [9:0]       Y_PRE      = 10'(Y_OFF - 1);
    localparam logic [9:0]       Y_END      = 10'(Y_OFF + GB_H * SCALE);
    localparam logic [9:0]       X_LAST     = 10'd799;
    localparam logic [7:0]       COL_LAST   = 8'(GB_W - 1);
    localparam logic [7:0]       ROW_LAST   = 8'(GB_H - 1);
    localparam logic [1:0]       PH_LAST    = 2'(SCALE - 1);
    localparam logic [FB_AW-1:0] ROW_STRIDE = FB_AW'(GB_W);

    fetch_state_t     r_state, w_next_state;
    logic [1:0]       r_col_phase, r_row_phase;
    logic [7:0]       r_src_col, r_src_row;
    logic             r_rd_sel, r_valid;
    logic [7:0]       r_fcol;
    logic [FB_AW-1:0] r_fetch_base;
    logic             r_fetch_buf;
    logic             r_rd_pend, r_rd_buf;
    logic [7:0]       r_rd_col;
    logic             r_underrun;

    logic             w_in_cols, w_in_rows, w_in_win;
    logic             w_frame_evt, w_row_evt, w_evt;
    logic [FB_AW-1:0] w_evt_base, w_cur_base;
    logic             w_evt_buf, w_cur_buf;
    logic [7:0]       w_cur_col;
    logic             w_fetching, w_force_fetch, w_grant_wr, w_issue;
    logic             w_lb_we;

    assign w_in_cols = (DrawX >= X_FIRST) && (DrawX < X_END);
    assign w_in_rows = (DrawY >= Y_FIRST) && (DrawY < Y_END);
    assign w_in_win  = w_in_cols && w_in_rows;

    // Row r+1 is fetched on the first screen line of row r, into the idle buffer.
    assign w_frame_evt = (DrawX == '0) && (DrawY == '0);
    assign w_row_evt   = (DrawX == '0) && w_in_rows && (r_row_phase == '0)
                         && (r_src_row < ROW_LAST);
    assign w_evt       = w_frame_evt || w_row_evt;
    assign w_evt_base  = w_frame_evt ? '0 : r_fetch_base + ROW_STRIDE;
    assign w_evt_buf   = w_frame_evt ? 1'b0 : ~r_rd_sel;

    // A fetch event restarts at column 0 and may issue in the same cycle.
    assign w_fetching = w_evt || (r_state == FETCH);
    assign w_cur_col  = w_evt ? '0 : r_fcol;
    assign w_cur_base = w_evt ? w_evt_base : r_fetch_base;
    assign w_cur_buf  = w_evt ? w_evt_buf : r_fetch_buf;

`ifdef FBARB_STARVE_GUARD_EN
    logic [3:0] r_wr_streak;

    assign w_force_fetch = (r_wr_streak == 4'd8) && w_fetching;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_streak <= '0;
        end else if (w_grant_wr && w_fetching) begin
            r_wr_streak <= r_wr_streak + 4'd1;
        end else begin
            r_wr_streak <= '0;
        end
    end
`else
    assign w_force_fetch = 1'b0;
`endif

    assign w_grant_wr = wr_req && !w_force_fetch;

    always_comb begin
        wr_ack    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_issue   = 1'b0;
        if (w_grant_wr) begin
            wr_ack    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (w_fetching) begin
            w_issue  = 1'b1;
            mem_addr = w_cur_base + FB_AW'(w_cur_col);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_evt) w_next_state = FETCH;
            FETCH:   if (!w_evt && w_issue && (r_fcol == COL_LAST)) w_next_state = DRAIN;
            DRAIN:   w_next_state = w_evt ? FETCH : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_fcol       <= '0;
            r_fetch_base <= '0;
            r_fetch_buf  <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_col     <= '0;
            r_rd_buf     <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_evt) begin
                r_fetch_base <= w_evt_base;
                r_fetch_buf  <= w_evt_buf;
            end
            if (w_issue) begin
                r_fcol <= w_cur_col + 8'd1;
            end else if (w_evt) begin
                r_fcol <= '0;
            end
            r_rd_pend <= w_issue;
            r_rd_col  <= w_cur_col;
            r_rd_buf  <= w_cur_buf;
            if (w_evt && (r_state != IDLE)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Data returning in an event cycle belongs to the aborted fetch.
    assign w_lb_we = r_rd_pend && !w_evt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_col_phase <= '0;
            r_src_col   <= '0;
            r_row_phase <= '0;
            r_src_row   <= '0;
            r_rd_sel    <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (DrawX == X_PRE) begin
                r_col_phase <= '0;
                r_src_col   <= '0;
            end else if (w_in_cols) begin
                if (r_col_phase == PH_LAST) begin
                    r_col_phase <= '0;
                    r_src_col   <= r_src_col + 8'd1;
                end else begin
                    r_col_phase <= r_col_phase + 2'd1;
                end
            end
            if (DrawX == X_LAST) begin
                if (DrawY == Y_PRE) begin
                    r_row_phase <= '0;
                    r_src_row   <= '0;
                end else if (w_in_rows) begin
                    if (r_row_phase == PH_LAST) begin
                        r_row_phase <= '0;
                        r_src_row   <= r_src_row + 8'd1;
                        r_rd_sel    <= ~r_rd_sel;
                    end else begin
                        r_row_phase <= r_row_phase + 2'd1;
                    end
                end
            end
            if (w_frame_evt) begin
                r_rd_sel <= 1'b0;
            end
            r_valid <= w_in_win;
        end
    end

    scan_line_buffer u_line_buf (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_we    (w_lb_we),
        .i_wsel  (r_rd_buf),
        .i_wcol  (r_rd_col),
        .i_wdata (mem_rdata),
        .i_re    (w_in_win),
        .i_rsel  (r_rd_sel),
        .i_rcol  (r_src_col),
        .o_rdata (pixel_shade)
    );

    assign pixel_valid = r_valid;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_frame_scanout_arbiter.sv
// Directed bench for frame_scanout_arbiter with a behavioural frame-buffer model.
module tb_frame_scanout_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_ack;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata = 2'd0;
    logic [1:0]  pixel_shade;
    logic        pixel_valid;
    logic        underrun;

    int total = 0;
    int bad   = 0;
    int x, y;

    logic [1:0] wr_ovr [int];

    always #5 Clk = ~Clk;

    frame_scanout_arbiter #(
        .FB_AW (15),
        .X_OFF (80),
        .Y_OFF (24)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pixel_shade (pixel_shade),
        .pixel_valid (pixel_valid),
        .underrun    (underrun)
    );

    // Initial content: col[1:0], except row 1 col 10 which is 0 so rows differ.
    function automatic logic [1:0] fb_init(input int a);
        if (a == 170) return 2'd0;
        return 2'(a % 160);
    endfunction

    always @(posedge Clk) begin
        if (mem_we) wr_ovr[int'(mem_addr)] = mem_wdata;
        else mem_rdata <= wr_ovr.exists(int'(mem_addr)) ? wr_ovr[int'(mem_addr)]
                                                        : fb_init(int'(mem_addr));
    end

    task automatic adv();
        x = x + 1;
        if (x == 800) begin
            x = 0;
            y = y + 1;
        end
        @(posedge Clk); #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
    endtask

    task automatic goto(input int nx, input int ny);
        x = nx;
        y = ny;
        @(posedge Clk); #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
    endtask

    task automatic run_to(input int nx, input int ny);
        int n = 0;
        while (!(x == nx && y == ny) && n < 20000) begin
            adv();
            n++;
        end
        if (n >= 20000) begin
            total++; bad++;
            $display("FAIL run_to: position %0d,%0d not reached, wanted %0d,%0d", x, y, nx, ny);
        end
    endtask

    task automatic check_pixel(input int row, input int ox);
        logic       ev;
        logic [1:0] es;
        int         col;
        ev  = (ox >= 80 && ox < 560);
        col = (ox - 80) / 3;
        es  = ev ? ((row == 1 && col == 10) ? 2'd0 : 2'(col)) : 2'd0;
        total++;
        if (pixel_valid !== ev || pixel_shade !== es) begin
            bad++;
            $display("FAIL pixel row%0d x%0d: got valid=%b shade=%0d want valid=%b shade=%0d",
                     row, ox, pixel_valid, pixel_shade, ev, es);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_wdata !== 2'd0) begin
            bad++;
            $display("FAIL reset_bus: got ack=%b we=%b addr=%0d wdata=%0d want all 0",
                     wr_ack, mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (pixel_shade !== 2'd0 || pixel_valid !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_pix: got shade=%0d valid=%b underrun=%b want all 0",
                     pixel_shade, pixel_valid, underrun);
        end
        Reset = 1'b0;
    endtask

    task automatic test_frame_fetch();
        goto(0, 0);
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd0) begin
            bad++;
            $display("FAIL fetch0_start: got we=%b addr=%0d want we=0 addr=0", mem_we, mem_addr);
        end
        run_to(5, 0);
        total++;
        if (mem_addr !== 15'd5) begin
            bad++;
            $display("FAIL fetch0_col5: got addr=%0d want 5", mem_addr);
        end
        run_to(159, 0);
        total++;
        if (mem_addr !== 15'd159) begin
            bad++;
            $display("FAIL fetch0_col159: got addr=%0d want 159", mem_addr);
        end
        run_to(160, 0);
        total++;
        if (mem_addr !== 15'd0) begin
            bad++;
            $display("FAIL fetch0_drain: got addr=%0d want 0", mem_addr);
        end
        goto(0, 23);
        run_to(0, 24);
        total++;
        if (mem_addr !== 15'd160) begin
            bad++;
            $display("FAIL fetch1_base: got addr=%0d want 160", mem_addr);
        end
        repeat (561) begin
            adv();
            if (x == 159) begin
                total++;
                if (mem_addr !== 15'd319) begin
                    bad++;
                    $display("FAIL fetch1_last: got addr=%0d want 319", mem_addr);
                end
            end
            if ((x - 1) inside {79, 80, 82, 83, 110, 559, 560}) check_pixel(0, x - 1);
        end
    endtask

    task automatic test_write_during_fetch();
        logic [1:0] got5;
        run_to(0, 27);
        total++;
        if (mem_addr !== 15'd320) begin
            bad++;
            $display("FAIL fetch2_base: got addr=%0d want 320", mem_addr);
        end
        repeat (561) begin
            adv();
            if (x == 10) begin
                wr_req  = 1'b1;
                wr_addr = 15'd5;
                wr_data = 2'd2;
                #1;
                total++;
                if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd5 || mem_wdata !== 2'd2) begin
                    bad++;
                    $display("FAIL write_grant: got ack=%b we=%b addr=%0d wdata=%0d want 1 1 5 2",
                             wr_ack, mem_we, mem_addr, mem_wdata);
                end
            end
            if (x == 11) begin
                wr_req = 1'b0;
                #1;
                total++;
                if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd330) begin
                    bad++;
                    $display("FAIL fetch_hold: got ack=%b we=%b addr=%0d want 0 0 330",
                             wr_ack, mem_we, mem_addr);
                end
                got5 = wr_ovr.exists(5) ? wr_ovr[5] : fb_init(5);
                total++;
                if (got5 !== 2'd2) begin
                    bad++;
                    $display("FAIL fb_write: got fb[5]=%0d want 2", got5);
                end
            end
            if (x == 160) begin
                total++;
                if (mem_addr !== 15'd479) begin
                    bad++;
                    $display("FAIL fetch2_last: got addr=%0d want 479", mem_addr);
                end
            end
            if (x == 161) begin
                total++;
                if (mem_addr !== 15'd0 || mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL fetch2_drain: got addr=%0d we=%b want 0 0", mem_addr, mem_we);
                end
            end
            if ((x - 1) inside {83, 110, 559}) check_pixel(1, x - 1);
        end
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL no_underrun: got %b want 0", underrun);
        end
    endtask

    task automatic test_sustained_writes();
        int reads = 0;
        int gaps_bad = 0;
        int last = -1;
        int cyc = 0;
        int exp_reads;
        logic exp_ur;
`ifdef FBARB_STARVE_GUARD_EN
        exp_reads = 155;
        exp_ur    = 1'b0;
`else
        exp_reads = 0;
        exp_ur    = 1'b1;
`endif
        goto(0, 0);
        run_to(200, 0);
        goto(0, 23);
        run_to(4, 24);
        adv();
        wr_req  = 1'b1;
        wr_addr = 15'd7;
        wr_data = 2'd1;
        #1;
        while (!(x == 0 && y == 27)) begin
            if (mem_we === 1'b0) begin
                reads++;
                if (last >= 0 && cyc - last != 9) gaps_bad++;
                last = cyc;
            end
            adv();
            cyc++;
        end
        total++;
        if (reads != exp_reads) begin
            bad++;
            $display("FAIL starve_reads: got %0d reads want %0d", reads, exp_reads);
        end
        total++;
        if (gaps_bad != 0) begin
            bad++;
            $display("FAIL starve_spacing: got %0d bad gaps want 0", gaps_bad);
        end
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL underrun_early: got %b want 0", underrun);
        end
        adv();
        total++;
        if (underrun !== exp_ur) begin
            bad++;
            $display("FAIL underrun_event: got %b want %b", underrun, exp_ur);
        end
        wr_req = 1'b0;
        run_to(300, 27);
    endtask

    task automatic test_reset_midfetch();
        goto(0, 0);
        run_to(50, 0);
        Reset = 1'b1;
        adv();
        total++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_wdata !== 2'd0) begin
            bad++;
            $display("FAIL midfetch_bus: got ack=%b we=%b addr=%0d wdata=%0d want all 0",
                     wr_ack, mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (pixel_shade !== 2'd0 || pixel_valid !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL midfetch_pix: got shade=%0d valid=%b underrun=%b want all 0",
                     pixel_shade, pixel_valid, underrun);
        end
        Reset = 1'b0;
        run_to(100, 0);
        total++;
        if (mem_addr !== 15'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got addr=%0d want 0", mem_addr);
        end
        goto(0, 23);
        run_to(1, 24);
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL underrun_after_reset: got %b want 0", underrun);
        end
    endtask

    initial begin
        Reset   = 1'b1;
        x       = 700;
        y       = 500;
        DrawX   = 10'd700;
        DrawY   = 10'd500;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        test_reset();
        test_frame_fetch();
        test_write_during_fetch();
        test_sustained_writes();
        test_reset_midfetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
